// File: rtl/timer_pkg.sv
// Shared definitions for the TC0/TC1 timer responders and the bridge decode.
// Word offsets are addr[3:2]; CTRL bit positions and mode encodings live here.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } timer_state_t;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;

    localparam int CTRL_ENABLE   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM       = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped down-counter timer: CTRL/PRESET/COUNT registers, a four-state
// sequencing FSM and a combinational read mux. intreq = irq flag AND IM.
//
// state   | meaning
// IDLE    | waiting for Enable
// LOAD    | COUNT <= PRESET
// CNT     | counting down; leaves on disable or terminal count
// INT     | terminal count reached; one-shot drops Enable, auto-reload drops the flag
module timer_counter
    import timer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        intreq
);

    timer_state_t state;
    logic         enable;
    logic [1:0]   mode;
    logic         im;
    logic [31:0]  preset;
    logic [31:0]  count;
    logic         irq_flag;

    logic [1:0]   word_sel;
    logic         wr_ctrl;
    logic         wr_preset;
    logic         irq_set;
    logic         unused_addr;

    assign word_sel    = addr[3:2];
    assign unused_addr = ^{addr[31:4], addr[1:0]};
    assign wr_ctrl     = we && (word_sel == REG_CTRL);
    assign wr_preset   = we && (word_sel == REG_PRESET);

    // Terminal count; PRESET = 0 lands here too, so it behaves like PRESET = 1.
    assign irq_set = (state == ST_CNT) && enable && (count <= 32'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            enable   <= 1'b0;
            mode     <= MODE_ONESHOT;
            im       <= 1'b0;
            preset   <= 32'd0;
            count    <= 32'd0;
            irq_flag <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    count <= preset;
                    state <= ST_CNT;
                end
                ST_CNT: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                    end else if (count > 32'd1) begin
                        count <= count - 32'd1;
                    end else begin
                        count    <= 32'd0;
                        irq_flag <= 1'b1;
                        state    <= ST_INT;
                    end
                end
                ST_INT: begin
                    if (mode == MODE_RELOAD) irq_flag <= 1'b0;
                    else                     enable   <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            // CPU writes come last so they override the FSM's Enable clear.
            if (wr_ctrl) begin
                enable <= wdata[CTRL_ENABLE];
                mode   <= wdata[CTRL_MODE_MSB:CTRL_MODE_LSB];
                im     <= wdata[CTRL_IM];
            end
            if (wr_preset) preset <= wdata;
            // A terminal count on the same edge beats the software clear.
            if ((wr_ctrl || wr_preset) && !irq_set) irq_flag <= 1'b0;
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (word_sel)
            REG_CTRL:   rdata = {28'd0, im, mode, enable};
            REG_PRESET: rdata = preset;
            REG_COUNT:  rdata = count;
            default:    rdata = 32'd0;
        endcase
    end

    assign intreq = irq_flag & im;

endmodule
